// File: rtl/costas_lock_ctrl_if.sv
// Control/status bundle between the channel controller, the Costas discriminator and
// the acquisition/tracking sequencer.
interface costas_lock_ctrl_if #(
    parameter int ERR_W = 28
);
    logic                    start;
    logic                    abort;
    logic                    err_valid;
    logic signed [ERR_W-1:0] phase_error;
    logic [1:0]              gain_sel;
    logic                    filt_clr;
    logic                    nco_load;
    logic                    lock;
    logic                    fail;
    logic [2:0]              state;

    modport master (
        output start, abort, err_valid, phase_error,
        input  gain_sel, filt_clr, nco_load, lock, fail, state
    );

    modport slave (
        input  start, abort, err_valid, phase_error,
        output gain_sel, filt_clr, nco_load, lock, fail, state
    );
endinterface

// File: rtl/costas_lock_ctrl.sv
// Costas loop acquisition/tracking sequencer: integrates |phase_error| per window,
// decides pull-in vs. lock, and drives loop-filter gain, filter clear and NCO reload.
module costas_lock_ctrl #(
    parameter int ERR_W     = 28,
    parameter int WIN_LEN   = 20,
    parameter int LOCK_THR  = 335544320,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 3,
    parameter int PULL_TMO  = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst,
    costas_lock_ctrl_if.slave   bus
);
    localparam int ACC_W  = ERR_W + $clog2(WIN_LEN);
    localparam int SCNT_W = $clog2(WIN_LEN);
    localparam int GCNT_W = $clog2(LOCK_CNT + 1);
    localparam int BCNT_W = $clog2(LOSS_CNT + 1);
    localparam int WCNT_W = $clog2(PULL_TMO + 1);
    localparam int RCNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [ERR_W-1:0] MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] MOST_POS = {1'b0, {(ERR_W-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PULL  = 3'd2,
        ST_TRACK = 3'd3,
        ST_LOST  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [RCNT_W-1:0]   retry_reg, retry_next;
    logic [ACC_W-1:0]    acc_reg;
    logic [SCNT_W-1:0]   scnt_reg;
    logic                win_done_reg, win_good_reg;
    logic [GCNT_W-1:0]   good_cnt_reg, good_inc;
    logic [BCNT_W-1:0]   bad_cnt_reg, bad_inc;
    logic [WCNT_W-1:0]   win_cnt_reg, win_inc;
    logic [ERR_W-1:0]    mag;
    logic [ACC_W-1:0]    acc_sum;
    logic                state_chg;
    logic                integrating;
    logic [1:0]          gain_reg, gain_next;
    logic                clr_reg, lock_reg, fail_reg;

    // |x| with the most-negative code clamped so it stays representable
    always_comb begin
        mag = bus.phase_error;
        if (bus.phase_error == MOST_NEG)
            mag = MOST_POS;
        else if (bus.phase_error[ERR_W-1])
            mag = $unsigned(-bus.phase_error);
    end

    assign acc_sum     = acc_reg + ACC_W'(mag);
    assign good_inc    = good_cnt_reg + 1'b1;
    assign bad_inc     = bad_cnt_reg + 1'b1;
    assign win_inc     = win_cnt_reg + 1'b1;
    assign state_chg   = (state_next != state_reg);
    assign integrating = (state_reg == ST_PULL || state_reg == ST_TRACK) && bus.err_valid;

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_CLEAR;
                    retry_next = '0;
                end
            end
            ST_CLEAR: state_next = ST_PULL;
            ST_PULL: begin
                if (win_done_reg) begin
                    if (win_good_reg && good_inc == GCNT_W'(LOCK_CNT))
                        state_next = ST_TRACK;
                    else if (win_inc == WCNT_W'(PULL_TMO))
                        state_next = ST_LOST;
                end
            end
            ST_TRACK: begin
                if (win_done_reg && !win_good_reg && bad_inc == BCNT_W'(LOSS_CNT))
                    state_next = ST_LOST;
            end
            ST_LOST: begin
                if (retry_reg < RCNT_W'(MAX_RETRY)) begin
                    retry_next = retry_reg + 1'b1;
                    state_next = ST_CLEAR;
                end else begin
                    state_next = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (bus.start) begin
                    state_next = ST_CLEAR;
                    retry_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_next = ST_IDLE;
            retry_next = retry_reg;
        end
    end

    always_comb begin
        gain_next = 2'b00;
        case (state_next)
            ST_PULL:  gain_next = 2'b11;
            ST_TRACK: gain_next = 2'b01;
            default:  gain_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            retry_reg <= '0;
            gain_reg  <= 2'b00;
            clr_reg   <= 1'b0;
            lock_reg  <= 1'b0;
            fail_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            gain_reg  <= gain_next;
            clr_reg   <= (state_next == ST_CLEAR);
            lock_reg  <= (state_next == ST_TRACK);
            fail_reg  <= (state_next == ST_FAIL);
        end
    end

    // Window integrator; a sample landing on a state change belongs to no window
    always_ff @(posedge clk) begin
        if (!rst || state_chg) begin
            acc_reg      <= '0;
            scnt_reg     <= '0;
            win_done_reg <= 1'b0;
            win_good_reg <= 1'b0;
        end else if (integrating) begin
            if (scnt_reg == SCNT_W'(WIN_LEN - 1)) begin
                acc_reg      <= '0;
                scnt_reg     <= '0;
                win_done_reg <= 1'b1;
                win_good_reg <= (acc_sum < ACC_W'(LOCK_THR));
            end else begin
                acc_reg      <= acc_sum;
                scnt_reg     <= scnt_reg + 1'b1;
                win_done_reg <= 1'b0;
            end
        end else begin
            win_done_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || state_chg) begin
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            win_cnt_reg  <= '0;
        end else if (win_done_reg) begin
            if (state_reg == ST_PULL) begin
                good_cnt_reg <= win_good_reg ? good_inc : '0;
                win_cnt_reg  <= win_inc;
            end else if (state_reg == ST_TRACK) begin
                bad_cnt_reg  <= win_good_reg ? '0 : bad_inc;
            end
        end
    end

    assign bus.state    = state_reg;
    assign bus.gain_sel = gain_reg;
    assign bus.filt_clr = clr_reg;
    assign bus.nco_load = clr_reg;
    assign bus.lock     = lock_reg;
    assign bus.fail     = fail_reg;
endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed bench for costas_lock_ctrl: a table of whole-window stimulus records plus
// hand-written sequences for reset, timeout/retry, FAIL and abort corners.
module tb_costas_lock_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    costas_lock_ctrl_if #(.ERR_W(28)) bus ();

    costas_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [27:0] pe;
        int                 nsamp;
        logic [2:0]         exp_state;
        logic [1:0]         exp_gain;
        logic               exp_lock;
    } vec_t;

    vec_t vecs [9];

    localparam logic signed [27:0] P24   = 28'sd16777216;
    localparam logic signed [27:0] P24M1 = 28'sd16777215;
    localparam logic signed [27:0] P20   = 28'sd1048576;
    localparam logic signed [27:0] P26   = 28'sd67108864;
    localparam logic signed [27:0] N26   = -28'sd67108864;
    localparam logic signed [27:0] N27   = 28'sh8000000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive n valid samples back to back; returns one cycle after the last one was taken
    task automatic feed(input logic signed [27:0] pe, input int n);
        for (int i = 0; i < n; i++) begin
            bus.err_valid   = 1'b1;
            bus.phase_error = pe;
            step();
        end
        bus.err_valid   = 1'b0;
        bus.phase_error = '0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] prev;
        bus.start = 1'b0; bus.abort = 1'b0; bus.err_valid = 1'b0; bus.phase_error = '0;
        rst = 1'b0;

        vecs[0] = '{P24,   20, 3'd2, 2'b11, 1'b0};  // sum == threshold: bad
        vecs[1] = '{P24M1, 60, 3'd2, 2'b11, 1'b0};  // three good
        vecs[2] = '{P24,   20, 3'd2, 2'b11, 1'b0};  // bad resets good count
        vecs[3] = '{P20,   60, 3'd2, 2'b11, 1'b0};
        vecs[4] = '{P20,   20, 3'd3, 2'b01, 1'b1};  // fourth consecutive good: lock
        vecs[5] = '{N26,   40, 3'd3, 2'b01, 1'b1};  // two bad
        vecs[6] = '{P20,   20, 3'd3, 2'b01, 1'b1};  // good resets bad count
        vecs[7] = '{N26,   40, 3'd3, 2'b01, 1'b1};
        vecs[8] = '{N27,   20, 3'd4, 2'b00, 1'b0};  // saturated most-negative: bad -> LOST

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state), 0);
        check("rst_gain",  32'(bus.gain_sel), 0);
        check("rst_flags", {27'd0, bus.filt_clr, bus.nco_load, bus.lock, bus.fail, 1'b0}, 0);
        rst = 1'b1;
        step();
        check("idle_state", 32'(bus.state), 0);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("clear_state", 32'(bus.state), 1);
        check("clear_filt",  32'(bus.filt_clr), 1);
        check("clear_nco",   32'(bus.nco_load), 1);
        check("clear_gain",  32'(bus.gain_sel), 0);
        step();
        check("pull_state", 32'(bus.state), 2);
        check("pull_gain",  32'(bus.gain_sel), 3);
        check("pull_filt",  32'(bus.filt_clr), 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("start_ign_pull", 32'(bus.state), 2);
        $display("[TB] reset/start sequence done, state=%0d", bus.state);

        prev = 3'd2;
        for (int v = 0; v < 9; v++) begin
            feed(vecs[v].pe, vecs[v].nsamp);
            check($sformatf("vec%0d_hold", v), 32'(bus.state), 32'(prev));
            step();
            check($sformatf("vec%0d_state", v), 32'(bus.state), 32'(vecs[v].exp_state));
            check($sformatf("vec%0d_gain", v),  32'(bus.gain_sel), 32'(vecs[v].exp_gain));
            check($sformatf("vec%0d_lock", v),  32'(bus.lock), 32'(vecs[v].exp_lock));
            $display("[TB] vec %0d pe=%0d n=%0d -> state=%0d gain=%0d lock=%0d",
                     v, vecs[v].pe, vecs[v].nsamp, bus.state, bus.gain_sel, bus.lock);
            prev = vecs[v].exp_state;
        end

        step();
        check("relost_clear", 32'(bus.state), 1);
        check("relost_filt",  32'(bus.filt_clr), 1);
        step();
        check("relost_pull", 32'(bus.state), 2);
        check("relost_gain", 32'(bus.gain_sel), 3);

        // three pull-in timeouts: LOST #2, #3 re-acquire, LOST #4 gives up
        for (int k = 0; k < 3; k++) begin
            feed(P26, 63 * 20);
            step();
            check($sformatf("tmo%0d_w63", k), 32'(bus.state), 2);
            feed(P26, 20);
            check($sformatf("tmo%0d_hold", k), 32'(bus.state), 2);
            step();
            check($sformatf("tmo%0d_lost", k), 32'(bus.state), 4);
            check($sformatf("tmo%0d_gain", k), 32'(bus.gain_sel), 0);
            step();
            check($sformatf("tmo%0d_after", k), 32'(bus.state), (k < 2) ? 1 : 5);
            if (k < 2) step();
            $display("[TB] timeout %0d -> state=%0d fail=%0d", k, bus.state, bus.fail);
        end
        check("fail_flag", 32'(bus.fail), 1);
        check("fail_gain", 32'(bus.gain_sel), 0);
        repeat (5) step();
        check("fail_sticky", 32'(bus.state), 5);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("fail_restart", 32'(bus.state), 1);
        check("fail_clr_flag", 32'(bus.fail), 0);
        step();
        check("restart_pull", 32'(bus.state), 2);
        feed(P20, 80);
        step();
        check("relock_state", 32'(bus.state), 3);
        check("relock_lock",  32'(bus.lock), 1);
        feed(N26, 40);
        step();
        check("track_bad2", 32'(bus.state), 3);

        // abort coincides with the window that would declare loss
        feed(N26, 20);
        bus.abort = 1'b1; bus.start = 1'b1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        check("abort_state", 32'(bus.state), 0);
        check("abort_gain",  32'(bus.gain_sel), 0);
        check("abort_lock",  32'(bus.lock), 0);
        $display("[TB] abort in TRACK -> state=%0d", bus.state);

        bus.abort = 1'b1; bus.start = 1'b1; step();
        bus.abort = 1'b0; bus.start = 1'b0;
        check("abort_over_start", 32'(bus.state), 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("idle_start", 32'(bus.state), 1);
        step();
        check("idle_start_pull", 32'(bus.state), 2);

        rst = 1'b0; step(); rst = 1'b1;
        check("midrst_state", 32'(bus.state), 0);
        check("midrst_gain",  32'(bus.gain_sel), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
